// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: CDB lanes, operand/entry records, widths.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ooo_pkg;

    localparam int DATA_W    = 16;
    localparam int TAG_W     = 4;
    localparam int OP_W      = 4;
    localparam int CDB_LANES = 4;

    typedef logic [OP_W-1:0]   opcode_t;
    typedef logic [TAG_W-1:0]  rob_tag_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic     valid;
        rob_tag_t index;
        data_t    value;
    } cdb_lane_t;

    typedef cdb_lane_t [CDB_LANES-1:0] cdb_bus_t;

    // One source operand: either a value (valid=1) or the ROB tag that will produce it.
    typedef struct packed {
        logic     valid;
        data_t    value;
        rob_tag_t owner;
    } rs_operand_t;

    typedef struct packed {
        opcode_t     opcode;
        rob_tag_t    rt;
        rs_operand_t a;
        rs_operand_t b;
    } rs_entry_t;

    // Lane 0 occupies the LSBs of each flat bus.
    function automatic cdb_bus_t cdb_unpack(
        input logic [CDB_LANES-1:0]        v,
        input logic [CDB_LANES*TAG_W-1:0]  idx,
        input logic [CDB_LANES*DATA_W-1:0] val
    );
        cdb_bus_t r;
        for (int l = 0; l < CDB_LANES; l++) begin
            r[l].valid = v[l];
            r[l].index = idx[l*TAG_W +: TAG_W];
            r[l].value = val[l*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    function automatic logic operands_ready(input rs_entry_t e);
        return e.a.valid && e.b.valid;
    endfunction

endpackage

// File: rtl/fxu_reservation_station_if.sv
// Dispatch, CDB snoop and issue signals of the FXU reservation station.
// Latency: n/a (wiring only).
// Backpressure: disp_ready toward dispatch, issue_ready from the FXU.
// Ports: master = environment (dispatch, CDB, FXU); slave = the station.
interface fxu_reservation_station_if;
    import ooo_pkg::*;

    logic                        disp_valid;
    logic                        disp_ready;
    opcode_t                     disp_opcode;
    logic                        disp_a_valid;
    data_t                       disp_a_value;
    rob_tag_t                    disp_a_owner;
    logic                        disp_b_valid;
    data_t                       disp_b_value;
    rob_tag_t                    disp_b_owner;
    rob_tag_t                    disp_rt;

    logic [CDB_LANES-1:0]        cdb_valid;
    logic [CDB_LANES*TAG_W-1:0]  cdb_index;
    logic [CDB_LANES*DATA_W-1:0] cdb_value;

    logic                        issue_valid;
    logic                        issue_ready;
    opcode_t                     issue_opcode;
    data_t                       issue_a;
    data_t                       issue_b;
    rob_tag_t                    issue_rt;

    modport master (
        output disp_valid, disp_opcode, disp_a_valid, disp_a_value, disp_a_owner,
               disp_b_valid, disp_b_value, disp_b_owner, disp_rt,
               cdb_valid, cdb_index, cdb_value, issue_ready,
        input  disp_ready, issue_valid, issue_opcode, issue_a, issue_b, issue_rt
    );

    modport slave (
        input  disp_valid, disp_opcode, disp_a_valid, disp_a_value, disp_a_owner,
               disp_b_valid, disp_b_value, disp_b_owner, disp_rt,
               cdb_valid, cdb_index, cdb_value, issue_ready,
        output disp_ready, issue_valid, issue_opcode, issue_a, issue_b, issue_rt
    );

endinterface

// File: rtl/rs_operand_wakeup.sv
// Single-operand CDB tag compare; a waiting operand captures the lowest matching lane.
// Latency: combinational, the caller registers op_out.
// Backpressure: none.
// Ports: op_in (current operand), cdb (all lanes), op_out (operand after capture).
module rs_operand_wakeup
    import ooo_pkg::*;
(
    input  rs_operand_t op_in,
    input  cdb_bus_t    cdb,
    output rs_operand_t op_out
);

    // Scan from the highest lane down so the lowest matching lane is written last and wins.
    always_comb begin
        op_out = op_in;
        if (!op_in.valid) begin
            for (int l = CDB_LANES - 1; l >= 0; l--) begin
                if (cdb[l].valid && (cdb[l].index == op_in.owner)) begin
                    op_out.valid = 1'b1;
                    op_out.value = cdb[l].value;
                end
            end
        end
    end

endmodule

// File: rtl/fxu_reservation_station.sv
// FXU reservation station: collapsing queue (slot 0 oldest), CDB wakeup, oldest-ready issue.
// Latency: dispatch with ready operands issues 1 cycle later; 0 cycles with RS_BYPASS_EN.
// Backpressure: disp_ready = count < DEPTH (ignores same-cycle issue); entries hold while !issue_ready.
// Ports: clk, rst_n (async active-low), flush (sync squash), rs_if (slave modport), count, full.
// Optional macro RS_BYPASS_EN: a ready dispatch goes straight to issue when no stored entry is ready.
module fxu_reservation_station
    import ooo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    fxu_reservation_station_if.slave     rs_if,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    rs_entry_t        q      [DEPTH];
    rs_entry_t        nxt_q  [DEPTH];
    // One extra zero slot so the shift-down can read slot i+1 uniformly.
    rs_entry_t        woke   [DEPTH+1];
    rs_operand_t      woke_a [DEPTH];
    rs_operand_t      woke_b [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    cdb_bus_t         cdb;
    rs_entry_t        disp_raw;
    rs_entry_t        disp_woke;
    rs_operand_t      disp_wa;
    rs_operand_t      disp_wb;

    logic [DEPTH-1:0] slot_rdy;
    logic             any_rdy;
    logic [CNT_W-1:0] sel;
    rs_entry_t        sel_entry;
    logic             disp_rdy;
    logic             accept;
    logic             byp;
    logic             st_issue;
    logic             wr;
    logic [CNT_W-1:0] wr_idx;

    assign cdb = cdb_unpack(rs_if.cdb_valid, rs_if.cdb_index, rs_if.cdb_value);

    // Stored-operand wakeup feeds next state only; readiness below uses registered bits.
    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        rs_operand_wakeup u_wake_a (.op_in(q[g].a), .cdb(cdb), .op_out(woke_a[g]));
        rs_operand_wakeup u_wake_b (.op_in(q[g].b), .cdb(cdb), .op_out(woke_b[g]));
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i]   = q[i];
            woke[i].a = woke_a[i];
            woke[i].b = woke_b[i];
        end
        woke[DEPTH] = '0;
    end

    always_comb begin
        disp_raw        = '0;
        disp_raw.opcode = rs_if.disp_opcode;
        disp_raw.rt     = rs_if.disp_rt;
        disp_raw.a      = '{valid: rs_if.disp_a_valid, value: rs_if.disp_a_value, owner: rs_if.disp_a_owner};
        disp_raw.b      = '{valid: rs_if.disp_b_valid, value: rs_if.disp_b_value, owner: rs_if.disp_b_owner};
    end

    // Same-cycle CDB capture for the instruction being written.
    rs_operand_wakeup u_wake_disp_a (.op_in(disp_raw.a), .cdb(cdb), .op_out(disp_wa));
    rs_operand_wakeup u_wake_disp_b (.op_in(disp_raw.b), .cdb(cdb), .op_out(disp_wb));

    always_comb begin
        disp_woke   = disp_raw;
        disp_woke.a = disp_wa;
        disp_woke.b = disp_wb;
    end

    // Oldest ready slot: scan downward so the lowest index is taken last.
    always_comb begin
        sel       = '0;
        sel_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_rdy[i] = (CNT_W'(i) < cnt_q) && operands_ready(q[i]);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_rdy[i]) begin
                sel       = CNT_W'(i);
                sel_entry = q[i];
            end
        end
    end

    assign any_rdy  = |slot_rdy;
    assign disp_rdy = (cnt_q < CNT_W'(DEPTH));
    assign accept   = rs_if.disp_valid && disp_rdy && !flush;

`ifdef RS_BYPASS_EN
    assign byp = accept && !any_rdy && disp_wa.valid && disp_wb.valid && rs_if.issue_ready;
`else
    assign byp = 1'b0;
`endif

    assign st_issue = any_rdy && !flush && rs_if.issue_ready;
    assign wr       = accept && !byp;
    // An issue always comes from a slot below count, so the tail moves down by one.
    assign wr_idx   = cnt_q - CNT_W'(st_issue);

    always_comb begin
        cnt_nxt = cnt_q + CNT_W'(wr) - CNT_W'(st_issue);
        for (int i = 0; i < DEPTH; i++) begin
            nxt_q[i] = woke[i];
            if (st_issue && (CNT_W'(i) >= sel)) begin
                nxt_q[i] = woke[i+1];
            end
            if (wr && (CNT_W'(i) == wr_idx)) begin
                nxt_q[i] = disp_woke;
            end
        end
        if (flush) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= nxt_q[i];
            end
        end
    end

    // Payload follows the oldest ready slot; it may change under backpressure.
    always_comb begin
        rs_if.issue_opcode = '0;
        rs_if.issue_a      = '0;
        rs_if.issue_b      = '0;
        rs_if.issue_rt     = '0;
        if (any_rdy) begin
            rs_if.issue_opcode = sel_entry.opcode;
            rs_if.issue_a      = sel_entry.a.value;
            rs_if.issue_b      = sel_entry.b.value;
            rs_if.issue_rt     = sel_entry.rt;
        end else if (byp) begin
            rs_if.issue_opcode = disp_woke.opcode;
            rs_if.issue_a      = disp_woke.a.value;
            rs_if.issue_b      = disp_woke.b.value;
            rs_if.issue_rt     = disp_woke.rt;
        end
    end

    assign rs_if.issue_valid = (any_rdy || byp) && !flush;
    assign rs_if.disp_ready  = disp_rdy;
    assign count             = cnt_q;
    assign full              = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_fxu_reservation_station.sv
// Directed table-driven bench for fxu_reservation_station (default build, no bypass).
// Latency: n/a.
// Backpressure: n/a.
module tb_fxu_reservation_station;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [2:0] count;
    logic       full;

    fxu_reservation_station_if bus ();

    fxu_reservation_station #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .rs_if (bus),
        .count (count),
        .full  (full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        flush;
        logic        dv;
        logic [3:0]  op;
        logic        av;
        logic [15:0] aval;
        logic [3:0]  aown;
        logic        bv;
        logic [15:0] bval;
        logic [3:0]  bown;
        logic [3:0]  rt;
        logic [3:0]  cv;
        logic [15:0] ci;
        logic [63:0] cval;
        logic        ir;
        logic        e_iv;
        logic [3:0]  e_op;
        logic [15:0] e_a;
        logic [15:0] e_b;
        logic [3:0]  e_rt;
        logic [2:0]  e_cnt;
        logic        e_full;
        logic        e_drdy;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[$];

    function automatic vec_t blank(input logic ir);
        vec_t v;
        v    = '0;
        v.ir = ir;
        return v;
    endfunction

    function automatic vec_t dsp(input vec_t vi, input logic [3:0] op,
                                 input logic av, input logic [15:0] aval, input logic [3:0] aown,
                                 input logic bv, input logic [15:0] bval, input logic [3:0] bown,
                                 input logic [3:0] rt);
        vec_t v;
        v = vi;
        v.dv = 1'b1; v.op = op; v.rt = rt;
        v.av = av; v.aval = aval; v.aown = aown;
        v.bv = bv; v.bval = bval; v.bown = bown;
        return v;
    endfunction

    function automatic vec_t cdbv(input vec_t vi, input logic [3:0] cv,
                                  input logic [15:0] ci, input logic [63:0] cval);
        vec_t v;
        v = vi;
        v.cv = cv; v.ci = ci; v.cval = cval;
        return v;
    endfunction

    function automatic vec_t fl(input vec_t vi);
        vec_t v;
        v = vi;
        v.flush = 1'b1;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t vi, input logic iv, input logic [3:0] op,
                                input logic [15:0] a, input logic [15:0] b, input logic [3:0] rt,
                                input logic [2:0] cnt, input logic fu, input logic drdy);
        vec_t v;
        v = vi;
        v.e_iv = iv; v.e_op = op; v.e_a = a; v.e_b = b; v.e_rt = rt;
        v.e_cnt = cnt; v.e_full = fu; v.e_drdy = drdy;
        return v;
    endfunction

    function automatic vec_t exi(input vec_t vi, input logic [2:0] cnt, input logic fu, input logic drdy);
        return ex(vi, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0, cnt, fu, drdy);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        flush              = v.flush;
        bus.disp_valid     = v.dv;
        bus.disp_opcode    = v.op;
        bus.disp_a_valid   = v.av;
        bus.disp_a_value   = v.aval;
        bus.disp_a_owner   = v.aown;
        bus.disp_b_valid   = v.bv;
        bus.disp_b_value   = v.bval;
        bus.disp_b_owner   = v.bown;
        bus.disp_rt        = v.rt;
        bus.cdb_valid      = v.cv;
        bus.cdb_index      = v.ci;
        bus.cdb_value      = v.cval;
        bus.issue_ready    = v.ir;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d.issue_valid", i), 64'(bus.issue_valid), 64'(v.e_iv));
        chk($sformatf("v%0d.count", i),       64'(count),           64'(v.e_cnt));
        chk($sformatf("v%0d.full", i),        64'(full),            64'(v.e_full));
        chk($sformatf("v%0d.disp_ready", i),  64'(bus.disp_ready),  64'(v.e_drdy));
        if (v.e_iv) begin
            chk($sformatf("v%0d.issue_opcode", i), 64'(bus.issue_opcode), 64'(v.e_op));
            chk($sformatf("v%0d.issue_a", i),      64'(bus.issue_a),      64'(v.e_a));
            chk($sformatf("v%0d.issue_b", i),      64'(bus.issue_b),      64'(v.e_b));
            chk($sformatf("v%0d.issue_rt", i),     64'(bus.issue_rt),     64'(v.e_rt));
        end
    endtask

    initial begin
        // Simple issue
        tbl.push_back(exi(dsp(blank(1), 4'h3, 1, 16'h0005, 0, 1, 16'h0007, 0, 4'h2), 0, 0, 1));
        tbl.push_back(ex(blank(1), 1, 4'h3, 16'h0005, 16'h0007, 4'h2, 1, 0, 1));
        tbl.push_back(exi(blank(1), 0, 0, 1));
        // CDB wakeup on lane 2
        tbl.push_back(exi(dsp(blank(1), 4'h1, 0, 16'h0, 4'h9, 1, 16'h0001, 0, 4'h3), 0, 0, 1));
        tbl.push_back(exi(cdbv(blank(1), 4'b0100, 16'h0900, 64'h0000_BEEF_0000_0000), 1, 0, 1));
        tbl.push_back(ex(blank(1), 1, 4'h1, 16'hBEEF, 16'h0001, 4'h3, 1, 0, 1));
        tbl.push_back(exi(blank(1), 0, 0, 1));
        // Two lanes match: lane 1 wins over lane 3; hold under !issue_ready
        tbl.push_back(exi(dsp(blank(1), 4'h2, 0, 16'h0, 4'h6, 1, 16'h0002, 0, 4'h4), 0, 0, 1));
        tbl.push_back(exi(cdbv(blank(0), 4'b1010, 16'h6060, 64'h3333_0000_1111_0000), 1, 0, 1));
        tbl.push_back(ex(blank(0), 1, 4'h2, 16'h1111, 16'h0002, 4'h4, 1, 0, 1));
        tbl.push_back(ex(blank(1), 1, 4'h2, 16'h1111, 16'h0002, 4'h4, 1, 0, 1));
        tbl.push_back(exi(blank(1), 0, 0, 1));
        // Fill with owners 1..4, rejected 5th, wake 3 and 1 together
        tbl.push_back(exi(dsp(blank(1), 4'h4, 0, 16'h0, 4'h1, 1, 16'h0010, 0, 4'h5), 0, 0, 1));
        tbl.push_back(exi(dsp(blank(1), 4'h5, 0, 16'h0, 4'h2, 1, 16'h0020, 0, 4'h6), 1, 0, 1));
        tbl.push_back(exi(dsp(blank(1), 4'h6, 0, 16'h0, 4'h3, 1, 16'h0030, 0, 4'h7), 2, 0, 1));
        tbl.push_back(exi(dsp(blank(1), 4'h7, 0, 16'h0, 4'h4, 1, 16'h0040, 0, 4'h8), 3, 0, 1));
        tbl.push_back(exi(dsp(blank(1), 4'h8, 1, 16'h00AA, 0, 1, 16'h00BB, 0, 4'h9), 4, 1, 0));
        tbl.push_back(exi(cdbv(blank(1), 4'b0011, 16'h0013, 64'h0000_0000_0111_0333), 4, 1, 0));
        tbl.push_back(ex(blank(1), 1, 4'h4, 16'h0111, 16'h0010, 4'h5, 4, 1, 0));
        tbl.push_back(ex(blank(1), 1, 4'h6, 16'h0333, 16'h0030, 4'h7, 3, 0, 1));
        tbl.push_back(exi(blank(1), 2, 0, 1));
        // Flush with 3 entries (one ready) and a concurrent dispatch
        tbl.push_back(exi(dsp(blank(0), 4'h9, 1, 16'h0055, 0, 1, 16'h0066, 0, 4'hA), 2, 0, 1));
        tbl.push_back(ex(blank(0), 1, 4'h9, 16'h0055, 16'h0066, 4'hA, 3, 0, 1));
        tbl.push_back(exi(fl(dsp(blank(1), 4'hA, 1, 16'h0077, 0, 1, 16'h0088, 0, 4'hB)), 3, 0, 1));
        tbl.push_back(exi(blank(1), 0, 0, 1));
        tbl.push_back(exi(cdbv(blank(1), 4'b0011, 16'h0042, 64'h0000_0000_0004_0002), 0, 0, 1));
        tbl.push_back(exi(blank(1), 0, 0, 1));
        // Same-cycle capture on dispatch
        tbl.push_back(exi(cdbv(dsp(blank(1), 4'hB, 0, 16'h0, 4'h5, 1, 16'h0009, 0, 4'hC),
                               4'b0001, 16'h0005, 64'h0000_0000_0000_1234), 0, 0, 1));
        tbl.push_back(ex(blank(1), 1, 4'hB, 16'h1234, 16'h0009, 4'hC, 1, 0, 1));
        tbl.push_back(exi(blank(1), 0, 0, 1));
        // Dispatch and issue on the same edge
        tbl.push_back(exi(dsp(blank(1), 4'hC, 1, 16'h0001, 0, 1, 16'h0002, 0, 4'hD), 0, 0, 1));
        tbl.push_back(ex(dsp(blank(1), 4'hD, 1, 16'h0003, 0, 1, 16'h0004, 0, 4'hE),
                         1, 4'hC, 16'h0001, 16'h0002, 4'hD, 1, 0, 1));
        tbl.push_back(ex(blank(1), 1, 4'hD, 16'h0003, 16'h0004, 4'hE, 1, 0, 1));
        tbl.push_back(exi(blank(1), 0, 0, 1));

        // Reset state
        rst_n = 1'b0;
        drive(blank(0));
        #2;
        chk("reset.count", 64'(count), 64'd0);
        chk("reset.full", 64'(full), 64'd0);
        chk("reset.disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("reset.issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("reset.issue_a", 64'(bus.issue_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #2;
            check_vec(i, tbl[i]);
        end

        // Asynchronous reset in the middle of a cycle with live entries
        @(negedge clk);
        drive(dsp(blank(0), 4'hE, 1, 16'h000A, 0, 1, 16'h000B, 0, 4'hF));
        @(negedge clk);
        drive(dsp(blank(0), 4'hF, 0, 16'h0, 4'h7, 1, 16'h0001, 0, 4'h1));
        @(negedge clk);
        drive(blank(0));
        #2;
        chk("pre_rst.count", 64'(count), 64'd2);
        chk("pre_rst.issue_valid", 64'(bus.issue_valid), 64'd1);
        chk("pre_rst.issue_a", 64'(bus.issue_a), 64'h000A);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.count", 64'(count), 64'd0);
        chk("mid_rst.full", 64'(full), 64'd0);
        chk("mid_rst.disp_ready", 64'(bus.disp_ready), 64'd1);
        chk("mid_rst.issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("mid_rst.issue_a", 64'(bus.issue_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(cdbv(blank(1), 4'b0001, 16'h0007, 64'h0000_0000_0000_7777));
        #2;
        chk("post_rst.count", 64'(count), 64'd0);
        chk("post_rst.issue_valid", 64'(bus.issue_valid), 64'd0);
        @(negedge clk);
        drive(blank(1));
        #2;
        chk("post_rst2.count", 64'(count), 64'd0);
        chk("post_rst2.issue_valid", 64'(bus.issue_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fxu_reservation_station.md
Name: fxu_reservation_station

Overview:
- Reservation station for one fixed-point unit (FXU).
- Directly downstream of the instruction buffer: it accepts one dispatched instruction per cycle, holding operand values or ROB-index owner tags.
- Snoops the common data bus (CDB) to capture missing operands.
- Issues the oldest fully-ready entry to the FXU over a valid/ready handshake.

Parameters:
- DEPTH, 4, number of entries
- DATA_W, 16, operand/result width
- TAG_W, 4, ROB index width (16-entry ROB)
- OP_W, 4, opcode width
- CDB_LANES, 4, CDB broadcast lanes snooped per cycle

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept (count < DEPTH)
- disp_opcode  in  OP_W  opcode
- disp_a_valid  in  1  operand A value present
- disp_a_value  in  DATA_W  operand A value
- disp_a_owner  in  TAG_W  ROB producer of A when not valid
- disp_b_valid, disp_b_value, disp_b_owner  in  1/DATA_W/TAG_W  same for operand B
- disp_rt  in  TAG_W  destination ROB index
- cdb_valid  in  CDB_LANES  per-lane broadcast valid
- cdb_index  in  CDB_LANES*TAG_W  per-lane ROB index, lane 0 in LSBs
- cdb_value  in  CDB_LANES*DATA_W  per-lane result
- issue_valid  out  1  issue candidate present
- issue_ready  in  1  FXU accepts
- issue_opcode, issue_a, issue_b, issue_rt  out  OP_W/DATA_W/DATA_W/TAG_W  issued payload
- count  out  $clog2(DEPTH+1)  occupied entries
- full  out  1  count == DEPTH

Behaviour:
- Reset (rst_n low, async): all entries invalid, count=0, full=0, disp_ready=1, issue_valid=0, payload outputs 0.
- Storage is a collapsing queue:
  - slot 0 is the oldest entry, and valid slots are contiguous from 0.
  - Each entry holds opcode, rt, and per operand {valid, value, owner}.
- Dispatch:
  - Accepted on disp_valid && disp_ready at the clock edge.
  - Written at slot count, or count-1 if an issue from a lower slot fires in the same edge.
  - disp_ready ignores same-cycle issue, so it is conservative.
- Wakeup:
  - Every cycle, each stored operand with valid=0 compares its owner against every lane with cdb_valid=1.
  - On a match, value <= cdb_value and valid <= 1 at the edge.
  - If multiple lanes match, the lowest lane wins.
  - The same compare applies to dispatch-time operands, so an operand broadcast in the dispatch cycle is captured on write.
- Ready = both stored operand valid bits set (registered state only); a CDB match affects readiness from the next cycle.
- Issue:
  - issue_valid = any ready entry && !flush.
  - The payload comes from the lowest-indexed (oldest) ready slot, combinationally from registers.
  - On issue_valid && issue_ready the entry is removed and higher slots shift down one.
  - The payload may change while issue_valid && !issue_ready, because an older entry can become ready.
- Latency: dispatch with both operands valid at edge N gives issue_valid during cycle N+1 (no bypass).
- Count:
  - count += accept - issue; full = (count == DEPTH).
  - Simultaneous dispatch and issue when count == DEPTH cannot occur, since disp_ready=0.
- Flush: at the edge all entries are invalidated and count=0; a dispatch in the flush cycle is dropped, and issue_valid=0 during the flush cycle.
- Reset asserted mid-operation clears everything immediately; pending handshakes are lost.

Optional Feature:
- RS_BYPASS_EN defined:
  - Condition: no stored entry is ready, the dispatched instruction's operands are both valid (including same-cycle CDB capture), and issue_ready=1.
  - Then the dispatch is presented on issue_* in the same cycle, issue_valid=1, and it is not written into the station.
  - Minimum latency becomes 0.
- Undefined: minimum latency is 1 cycle, as above.

Decomposition:
- Shared package ooo_pkg holds:
  - DATA_W, TAG_W, OP_W, CDB_LANES constants
  - opcode_t, rob_tag_t, data_t typedefs
  - cdb_lane_t struct {valid, index, value}
  - rs_entry_t struct.
- One natural sub-module: rs_operand_wakeup, a single operand's CDB tag compare/capture with lowest-lane priority.
  - Instantiated 2*DEPTH times for stored operands, plus 2 for dispatch.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> count=0, full=0, disp_ready=1, issue_valid=0 immediately.
- Simple issue: dispatch op=3, a=0x0005, b=0x0007 (both valid), rt=2, issue_ready=1 -> next cycle issue_valid=1 with a=0x0005, b=0x0007, rt=2; count returns to 0.
- CDB wakeup:
  - Stimulus: dispatch a owner=9 (invalid), b=0x0001 valid; one cycle later cdb lane 2 valid, index=9, value=0xBEEF.
  - Response: issue_valid rises the cycle after the broadcast, with issue_a=0xBEEF.
- Full and ordering:
  - Stimulus: dispatch 4 entries waiting on owners 1..4.
  - Expected: full=1, disp_ready=0, and a 5th dispatch is not accepted.
  - Stimulus: broadcast owners 3 and 1 together.
  - Expected: the owner-1 entry issues first, then owner-3; count goes 4->3->2.
- Same-cycle capture: dispatch with a owner=5 while cdb lane 0 broadcasts index 5, value 0x1234 -> issue next cycle with a=0x1234.
- Flush: with 3 entries, one ready, and a concurrent dispatch, assert flush -> issue_valid=0 that cycle; count=0 next cycle; the dropped dispatch never issues.
